rob_mc: RTL and testbench
=========================

ROB_MC -- requirements
Module: rob_mc

Interface
REQ-001 Parameter DEPTH, 16: number of entries; power of two, 4..64.
REQ-002 Parameter IDX_W, log2(DEPTH): entry index width.
REQ-003 Parameter COMMIT_W, 2: maximum commits per cycle; 1 or 2.
REQ-004 Parameter NUM_WB, 2: number of writeback ports.
REQ-005 Parameter DATA_W, 32: result width; ADDR_W, 32: PC width.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 rdy  in  1  global enable; when low, state SHALL hold and all pulse outputs SHALL be 0.
REQ-009 issue_valid, issue_rd[4:0], issue_kind[1:0] (0 reg-write, 1 store, 2 branch, 3 jalr), issue_pc[ADDR_W], issue_pred_jump, issue_ready  in: allocate at tail.
REQ-010 issue_pos  out  IDX_W  current tail index; full  out  1  count==DEPTH; count  out  IDX_W+1  occupied entries.
REQ-011 wb_valid[NUM_WB], wb_pos[NUM_WB*IDX_W], wb_val[NUM_WB*DATA_W], wb_jump[NUM_WB], wb_pc[NUM_WB*ADDR_W]  in: result broadcast.
REQ-012 rs1_pos/rs2_pos  in  IDX_W; rs1_ready/rs2_ready  out  1; rs1_val/rs2_val  out  DATA_W: operand query.
REQ-013 commit_valid[COMMIT_W], commit_rd[COMMIT_W*5], commit_val[COMMIT_W*DATA_W], commit_pos[COMMIT_W*IDX_W]  out: registered regfile write pulses (commit_valid only for kind 0).
REQ-014 store_commit  out  1, store_pos  out  IDX_W: registered store release.
REQ-015 br_commit, br_jump  out  1, br_pc  out  ADDR_W: registered predictor update.
REQ-016 rollback  out  1, redirect_pc  out  ADDR_W: registered flush and fetch redirect.
REQ-017 head_pos  out  IDX_W: current head index.

Function
REQ-018 Issue SHALL be accepted when issue_valid && !full && !rollback; ignored otherwise; tail wraps modulo DEPTH.
REQ-019 Slot 0 SHALL commit head when count>0 and entry ready.
REQ-020 Slot k>0 SHALL commit head+k only if slots 0..k-1 committed, k<count, entry ready, no earlier slot this cycle mispredicted, and group holds at most one store and one branch/jalr.
REQ-021 Misprediction: kind 2 or 3 with pred_jump != res_jump; it SHALL be the last slot committed that cycle.
REQ-022 count_next SHALL equal count + accepted_issue - commits; issue and commit in the same cycle on a full ROB SHALL NOT be accepted (full is registered).
REQ-023 Writeback k SHALL set ready, val, res_jump, res_pc of wb_pos[k]; same-index collisions: higher k wins.
REQ-024 Writeback to the entry being issued in the same cycle SHALL be discarded (issue wins).
REQ-025 Query SHALL bypass: rsN_ready=1, rsN_val=wb_val[k] when wb_valid[k] && wb_pos[k]==rsN_pos this cycle; else stored values.
REQ-026 All commit outputs SHALL be valid one cycle after the commit decision, one cycle wide.
REQ-027 On misprediction commit: rollback=1 and redirect_pc=res_pc next cycle; same edge SHALL clear head, tail, count and all ready bits.
REQ-028 While rollback=1, issue and writebacks SHALL be ignored; rollback SHALL drop after one cycle.
REQ-029 Kind 2 SHALL always pulse br_commit; kind 3 SHALL not.

Reset
REQ-030 rst_n low SHALL immediately clear head, tail, count, all ready bits and all outputs to 0, mid-operation included.
REQ-031 First issue SHALL be accepted on the first rdy cycle after rst_n rises.

Verification
REQ-032 Issue 3 kind-0 entries (rd 1,2,3) issue_ready=1 -> commit_valid=2'b11 (rd 1,2) then 2'b01 (rd 3); count 3->1->0.
REQ-033 Fill 16 entries -> full=1; 17th issue ignored, issue_pos unchanged; commit one -> full=0 next cycle.
REQ-034 Head branch pred 0, wb_jump=1, wb_pc=0x100; head+1 ready -> only slot 0 commits; next cycle rollback=1, redirect_pc=0x100, count=0.
REQ-035 Two ready stores at head -> store_commit in two consecutive cycles, store_pos 0 then 1.
REQ-036 wb_pos=5 val 0xDEAD with rs1_pos=5 same cycle -> rs1_ready=1, rs1_val=0xDEAD combinationally.
REQ-037 rst_n pulsed low with count=7 -> count=0, all outputs 0 without a clock edge.

Source files
------------

// File: rtl/rob_if.sv
// Handshake and result bus between the reorder buffer and its issue, writeback,
// operand-query and commit clients.
interface rob_if #(
   parameter int DEPTH    = 16,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter int COMMIT_W = 2,
   parameter int NUM_WB   = 2,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32
);
   logic                       issue_valid;
   logic [4:0]                 issue_rd;
   logic [1:0]                 issue_kind;
   logic [ADDR_W-1:0]          issue_pc;
   logic                       issue_pred_jump;
   logic                       issue_ready;
   logic [IDX_W-1:0]           issue_pos;
   logic                       full;
   logic [IDX_W:0]             count;

   logic [NUM_WB-1:0]          wb_valid;
   logic [NUM_WB*IDX_W-1:0]    wb_pos;
   logic [NUM_WB*DATA_W-1:0]   wb_val;
   logic [NUM_WB-1:0]          wb_jump;
   logic [NUM_WB*ADDR_W-1:0]   wb_pc;

   logic [IDX_W-1:0]           rs1_pos;
   logic [IDX_W-1:0]           rs2_pos;
   logic                       rs1_ready;
   logic                       rs2_ready;
   logic [DATA_W-1:0]          rs1_val;
   logic [DATA_W-1:0]          rs2_val;

   logic [COMMIT_W-1:0]        commit_valid;
   logic [COMMIT_W*5-1:0]      commit_rd;
   logic [COMMIT_W*DATA_W-1:0] commit_val;
   logic [COMMIT_W*IDX_W-1:0]  commit_pos;
   logic                       store_commit;
   logic [IDX_W-1:0]           store_pos;
   logic                       br_commit;
   logic                       br_jump;
   logic [ADDR_W-1:0]          br_pc;
   logic                       rollback;
   logic [ADDR_W-1:0]          redirect_pc;
   logic [IDX_W-1:0]           head_pos;

   modport master (
      output issue_valid, issue_rd, issue_kind, issue_pc, issue_pred_jump, issue_ready,
      output wb_valid, wb_pos, wb_val, wb_jump, wb_pc, rs1_pos, rs2_pos,
      input  issue_pos, full, count, rs1_ready, rs2_ready, rs1_val, rs2_val,
      input  commit_valid, commit_rd, commit_val, commit_pos, store_commit, store_pos,
      input  br_commit, br_jump, br_pc, rollback, redirect_pc, head_pos
   );

   modport slave (
      input  issue_valid, issue_rd, issue_kind, issue_pc, issue_pred_jump, issue_ready,
      input  wb_valid, wb_pos, wb_val, wb_jump, wb_pc, rs1_pos, rs2_pos,
      output issue_pos, full, count, rs1_ready, rs2_ready, rs1_val, rs2_val,
      output commit_valid, commit_rd, commit_val, commit_pos, store_commit, store_pos,
      output br_commit, br_jump, br_pc, rollback, redirect_pc, head_pos
   );
endinterface

// File: rtl/rob_mc.sv
// Reorder buffer: in-order multi-slot commit, writeback bypass for operand
// queries, and a one-cycle flush when a mispredicted branch/jalr commits.
module rob_mc #(
   parameter int DEPTH    = 16,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter int COMMIT_W = 2,
   parameter int NUM_WB   = 2,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32
) (
   input logic  clk,
   input logic  rst_n,
   input logic  rdy,
   rob_if.slave bus
);
   localparam int CNT_W = IDX_W + 1;
   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam logic [1:0] KIND_REG    = 2'd0;
   localparam logic [1:0] KIND_STORE  = 2'd1;
   localparam logic [1:0] KIND_BRANCH = 2'd2;

   logic [4:0]        rd_mem   [DEPTH];
   logic [1:0]        kind_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic              pred_mem [DEPTH];
   logic [DATA_W-1:0] val_mem  [DEPTH];
   logic              jump_mem [DEPTH];
   logic [ADDR_W-1:0] rpc_mem  [DEPTH];

   logic [DEPTH-1:0] ready_q;
   idx_t             head_q;
   idx_t             tail_q;
   cnt_t             count_q;

   logic [COMMIT_W-1:0]        commit_vld_p1;
   logic [COMMIT_W*5-1:0]      commit_rd_p1;
   logic [COMMIT_W*DATA_W-1:0] commit_val_p1;
   logic [COMMIT_W*IDX_W-1:0]  commit_pos_p1;
   logic                       store_vld_p1;
   idx_t                       store_pos_p1;
   logic                       br_vld_p1;
   logic                       br_jump_p1;
   logic [ADDR_W-1:0]          br_pc_p1;
   logic                       rollback_p1;
   logic [ADDR_W-1:0]          redirect_p1;

   logic                full;
   logic                issue_acc;
   logic [NUM_WB-1:0]   wb_keep;
   idx_t                slot_pos [COMMIT_W];
   logic [COMMIT_W-1:0] do_commit;
   cnt_t                n_commit;
   logic                flush;
   logic                chain;
   logic                has_store;
   logic                has_br;
   logic                st_vld;
   idx_t                st_pos;
   logic                br_vld;
   logic                br_jump;
   logic [ADDR_W-1:0]   br_pc;
   logic [ADDR_W-1:0]   redir;
   logic                q1_rdy;
   logic                q2_rdy;
   logic [DATA_W-1:0]   q1_val;
   logic [DATA_W-1:0]   q2_val;

   function automatic logic mispredicts(input logic [1:0] kind, input logic pred, input logic jump);
      return kind[1] && (pred != jump);
   endfunction

   assign full      = (count_q == cnt_t'(DEPTH));
   assign issue_acc = rdy && bus.issue_valid && !full && !rollback_p1;

   // A writeback aimed at the slot being allocated this cycle loses to the issue.
   always_comb begin
      wb_keep = '0;
      for (int k = 0; k < NUM_WB; k++)
         wb_keep[k] = rdy && !rollback_p1 && bus.wb_valid[k]
                      && !(issue_acc && bus.wb_pos[k*IDX_W +: IDX_W] == tail_q);
   end

   // Commit selection: contiguous ready entries from head, stopping after a
   // mispredict or at a second store / second control-flow entry.
   always_comb begin
      chain     = rdy;
      has_store = 1'b0;
      has_br    = 1'b0;
      do_commit = '0;
      n_commit  = '0;
      flush     = 1'b0;
      st_vld    = 1'b0;
      st_pos    = '0;
      br_vld    = 1'b0;
      br_jump   = 1'b0;
      br_pc     = '0;
      redir     = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         slot_pos[k] = head_q + idx_t'(k);
         if (chain && cnt_t'(k) < count_q && ready_q[slot_pos[k]]
             && !(kind_mem[slot_pos[k]] == KIND_STORE && has_store)
             && !(kind_mem[slot_pos[k]][1] && has_br)) begin
            do_commit[k] = 1'b1;
            n_commit     = n_commit + cnt_t'(1);
            if (kind_mem[slot_pos[k]] == KIND_STORE) begin
               has_store = 1'b1;
               st_vld    = 1'b1;
               st_pos    = slot_pos[k];
            end
            if (kind_mem[slot_pos[k]][1])
               has_br = 1'b1;
            if (kind_mem[slot_pos[k]] == KIND_BRANCH) begin
               br_vld  = 1'b1;
               br_jump = jump_mem[slot_pos[k]];
               br_pc   = pc_mem[slot_pos[k]];
            end
            if (mispredicts(kind_mem[slot_pos[k]], pred_mem[slot_pos[k]], jump_mem[slot_pos[k]])) begin
               flush = 1'b1;
               redir = rpc_mem[slot_pos[k]];
               chain = 1'b0;
            end
         end else begin
            chain = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_keep[k]) begin
            val_mem[bus.wb_pos[k*IDX_W +: IDX_W]]  <= bus.wb_val[k*DATA_W +: DATA_W];
            jump_mem[bus.wb_pos[k*IDX_W +: IDX_W]] <= bus.wb_jump[k];
            rpc_mem[bus.wb_pos[k*IDX_W +: IDX_W]]  <= bus.wb_pc[k*ADDR_W +: ADDR_W];
         end
      end
      if (issue_acc) begin
         rd_mem[tail_q]   <= bus.issue_rd;
         kind_mem[tail_q] <= bus.issue_kind;
         pc_mem[tail_q]   <= bus.issue_pc;
         pred_mem[tail_q] <= bus.issue_pred_jump;
         val_mem[tail_q]  <= '0;
         jump_mem[tail_q] <= 1'b0;
         rpc_mem[tail_q]  <= '0;
      end
   end

   // Commit stage boundary: decisions become one-cycle output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         ready_q       <= '0;
         commit_vld_p1 <= '0;
         commit_rd_p1  <= '0;
         commit_val_p1 <= '0;
         commit_pos_p1 <= '0;
         store_vld_p1  <= 1'b0;
         store_pos_p1  <= '0;
         br_vld_p1     <= 1'b0;
         br_jump_p1    <= 1'b0;
         br_pc_p1      <= '0;
         rollback_p1   <= 1'b0;
         redirect_p1   <= '0;
      end else if (rdy) begin
         for (int k = 0; k < COMMIT_W; k++) begin
            commit_vld_p1[k]                 <= do_commit[k] && kind_mem[slot_pos[k]] == KIND_REG;
            commit_rd_p1[k*5 +: 5]           <= rd_mem[slot_pos[k]];
            commit_val_p1[k*DATA_W +: DATA_W] <= val_mem[slot_pos[k]];
            commit_pos_p1[k*IDX_W +: IDX_W]  <= slot_pos[k];
         end
         store_vld_p1 <= st_vld;
         store_pos_p1 <= st_pos;
         br_vld_p1    <= br_vld;
         br_jump_p1   <= br_jump;
         br_pc_p1     <= br_pc;
         rollback_p1  <= flush;
         redirect_p1  <= redir;
         if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= '0;
         end else begin
            head_q  <= head_q + idx_t'(n_commit);
            tail_q  <= tail_q + idx_t'(issue_acc);
            count_q <= count_q + cnt_t'(issue_acc) - n_commit;
            for (int k = 0; k < NUM_WB; k++)
               if (wb_keep[k])
                  ready_q[bus.wb_pos[k*IDX_W +: IDX_W]] <= 1'b1;
            if (issue_acc)
               ready_q[tail_q] <= bus.issue_ready;
         end
      end
   end

   always_comb begin
      q1_rdy = ready_q[bus.rs1_pos];
      q1_val = val_mem[bus.rs1_pos];
      q2_rdy = ready_q[bus.rs2_pos];
      q2_val = val_mem[bus.rs2_pos];
      for (int k = 0; k < NUM_WB; k++) begin
         if (bus.wb_valid[k] && bus.wb_pos[k*IDX_W +: IDX_W] == bus.rs1_pos) begin
            q1_rdy = 1'b1;
            q1_val = bus.wb_val[k*DATA_W +: DATA_W];
         end
         if (bus.wb_valid[k] && bus.wb_pos[k*IDX_W +: IDX_W] == bus.rs2_pos) begin
            q2_rdy = 1'b1;
            q2_val = bus.wb_val[k*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.issue_pos    = tail_q;
   assign bus.full         = full;
   assign bus.count        = count_q;
   assign bus.head_pos     = head_q;
   assign bus.rs1_ready    = rst_n && q1_rdy;
   assign bus.rs2_ready    = rst_n && q2_rdy;
   assign bus.rs1_val      = rst_n ? q1_val : '0;
   assign bus.rs2_val      = rst_n ? q2_val : '0;
   assign bus.commit_valid = rdy ? commit_vld_p1 : '0;
   assign bus.commit_rd    = commit_rd_p1;
   assign bus.commit_val   = commit_val_p1;
   assign bus.commit_pos   = commit_pos_p1;
   assign bus.store_commit = rdy && store_vld_p1;
   assign bus.store_pos    = store_pos_p1;
   assign bus.br_commit    = rdy && br_vld_p1;
   assign bus.br_jump      = br_jump_p1;
   assign bus.br_pc        = br_pc_p1;
   assign bus.rollback     = rdy && rollback_p1;
   assign bus.redirect_pc  = redirect_p1;
endmodule

// File: tb/tb_rob_mc.sv
// Self-checking bench for rob_mc: directed scenarios followed by randomized
// traffic compared against a queue-based reference model.
module tb_rob_mc;
   localparam int DEPTH = 16, IDX_W = 4, COMMIT_W = 2, NUM_WB = 2, DATA_W = 32, ADDR_W = 32;

   logic clk, rst_n, rdy;

   rob_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .COMMIT_W(COMMIT_W), .NUM_WB(NUM_WB),
            .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   rob_mc #(.DEPTH(DEPTH), .IDX_W(IDX_W), .COMMIT_W(COMMIT_W), .NUM_WB(NUM_WB),
            .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, want);
      end
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic [1:0]  kind;
      logic [31:0] pc;
      logic        pred;
      logic        ready;
      logic [31:0] val;
      logic        jump;
      logic [31:0] rpc;
   } ent_t;

   ent_t        q[$];
   int          mh;
   logic [1:0]  e_cv;
   logic [4:0]  e_crd  [2];
   logic [31:0] e_cval [2];
   logic [3:0]  e_cpos [2];
   logic        e_sc, e_bc, e_bj, e_rb;
   logic [3:0]  e_spos;
   logic [31:0] e_bpc, e_rpc;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      rdy = 1'b1;
      bus.issue_valid = 0; bus.issue_rd = 0; bus.issue_kind = 0; bus.issue_pc = 0;
      bus.issue_pred_jump = 0; bus.issue_ready = 0;
      bus.wb_valid = '0; bus.wb_pos = '0; bus.wb_val = '0; bus.wb_jump = '0; bus.wb_pc = '0;
      bus.rs1_pos = 0; bus.rs2_pos = 0;
   endtask

   task automatic model_reset();
      q.delete();
      mh = 0;
      e_cv = 0; e_sc = 0; e_bc = 0; e_bj = 0; e_rb = 0; e_spos = 0; e_bpc = 0; e_rpc = 0;
      for (int k = 0; k < 2; k++) begin e_crd[k] = 0; e_cval[k] = 0; e_cpos[k] = 0; end
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic iss(input int rd, input int kind, input bit pred, input bit rdyb, input int pc);
      bus.issue_valid = 1; bus.issue_rd = 5'(rd); bus.issue_kind = 2'(kind);
      bus.issue_pred_jump = pred; bus.issue_ready = rdyb; bus.issue_pc = 32'(pc);
   endtask

   task automatic wbd(input int k, input int pos, input int val, input bit jump, input int pc);
      bus.wb_valid[k] = 1'b1;
      bus.wb_pos[k*IDX_W +: IDX_W] = 4'(pos);
      bus.wb_val[k*DATA_W +: DATA_W] = 32'(val);
      bus.wb_jump[k] = jump;
      bus.wb_pc[k*ADDR_W +: ADDR_W] = 32'(pc);
   endtask

   // Reference step: applies one enabled clock edge to the queue model.
   task automatic model_step();
      int   n = 0;
      bit   st = 0, br = 0, mis = 0, acc;
      int   tail;
      ent_t ne;
      e_cv = 0; e_sc = 0; e_bc = 0;
      for (int k = 0; k < COMMIT_W; k++) begin
         if (k >= q.size() || !q[k].ready) break;
         if (q[k].kind == 1 && st) break;
         if (q[k].kind[1] && br) break;
         n++;
         if (q[k].kind == 0) begin
            e_cv[k] = 1; e_crd[k] = q[k].rd; e_cval[k] = q[k].val; e_cpos[k] = 4'((mh + k) % DEPTH);
         end
         if (q[k].kind == 1) begin e_sc = 1; e_spos = 4'((mh + k) % DEPTH); st = 1; end
         if (q[k].kind == 2) begin e_bc = 1; e_bj = q[k].jump; e_bpc = q[k].pc; end
         if (q[k].kind[1]) br = 1;
         if (q[k].kind[1] && q[k].pred != q[k].jump) begin mis = 1; e_rpc = q[k].rpc; break; end
      end
      acc  = bus.issue_valid && q.size() < DEPTH && !e_rb;
      tail = (mh + q.size()) % DEPTH;
      if (!e_rb) begin
         for (int k = 0; k < NUM_WB; k++) begin
            int p = int'(bus.wb_pos[k*IDX_W +: IDX_W]);
            int off = (p - mh + DEPTH) % DEPTH;
            if (!bus.wb_valid[k] || (acc && p == tail) || off >= q.size()) continue;
            q[off].ready = 1;
            q[off].val   = bus.wb_val[k*DATA_W +: DATA_W];
            q[off].jump  = bus.wb_jump[k];
            q[off].rpc   = bus.wb_pc[k*ADDR_W +: ADDR_W];
         end
      end
      repeat (n) void'(q.pop_front());
      if (acc) begin
         ne.rd = bus.issue_rd; ne.kind = bus.issue_kind; ne.pc = bus.issue_pc;
         ne.pred = bus.issue_pred_jump; ne.ready = bus.issue_ready;
         ne.val = 0; ne.jump = 0; ne.rpc = 0;
         q.push_back(ne);
      end
      e_rb = mis;
      if (mis) begin q.delete(); mh = 0; end
      else mh = (mh + n) % DEPTH;
   endtask

   task automatic chk_query(input string nm, input logic [3:0] p, input logic got_r, input logic [31:0] got_v);
      bit          known = 0;
      logic        er = 0;
      logic [31:0] ev = 0;
      int          off = (int'(p) - mh + DEPTH) % DEPTH;
      if (off < q.size()) begin known = 1; er = q[off].ready; ev = q[off].val; end
      for (int k = 0; k < NUM_WB; k++)
         if (bus.wb_valid[k] && bus.wb_pos[k*IDX_W +: IDX_W] == p) begin
            known = 1; er = 1; ev = bus.wb_val[k*DATA_W +: DATA_W];
         end
      if (known) begin
         chk({nm, "_ready"}, got_r, er);
         if (er) chk({nm, "_val"}, got_v, ev);
      end
   endtask

   task automatic compare_model();
      chk("r_count", bus.count, q.size());
      chk("r_full", bus.full, q.size() == DEPTH);
      chk("r_head", bus.head_pos, mh);
      chk("r_tail", bus.issue_pos, (mh + q.size()) % DEPTH);
      chk("r_cvalid", bus.commit_valid, rdy ? e_cv : 2'b00);
      for (int k = 0; k < COMMIT_W; k++)
         if (rdy && e_cv[k]) begin
            chk("r_crd", bus.commit_rd[k*5 +: 5], e_crd[k]);
            chk("r_cval", bus.commit_val[k*DATA_W +: DATA_W], e_cval[k]);
            chk("r_cpos", bus.commit_pos[k*IDX_W +: IDX_W], e_cpos[k]);
         end
      chk("r_store", bus.store_commit, rdy && e_sc);
      if (rdy && e_sc) chk("r_spos", bus.store_pos, e_spos);
      chk("r_br", bus.br_commit, rdy && e_bc);
      if (rdy && e_bc) begin
         chk("r_bjump", bus.br_jump, e_bj);
         chk("r_bpc", bus.br_pc, e_bpc);
      end
      chk("r_rollback", bus.rollback, rdy && e_rb);
      if (rdy && e_rb) chk("r_redirect", bus.redirect_pc, e_rpc);
      chk_query("r_rs1", bus.rs1_pos, bus.rs1_ready, bus.rs1_val);
      chk_query("r_rs2", bus.rs2_pos, bus.rs2_ready, bus.rs2_val);
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #2;
      chk("rst_async_count", bus.count, 0);
      do_reset();
      #1;
      chk("rst_count", bus.count, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_head", bus.head_pos, 0);
      chk("rst_tail", bus.issue_pos, 0);
      chk("rst_cvalid", bus.commit_valid, 0);
      chk("rst_rollback", bus.rollback, 0);

      // three reg-writes, head one held unready so both slots fire together
      iss(1, 0, 0, 0, 'h40); cyc(); #1;
      chk("first_issue_count", bus.count, 1);
      iss(2, 0, 0, 1, 'h44); cyc();
      iss(3, 0, 0, 1, 'h48); cyc(); #1;
      chk("three_count", bus.count, 3);
      chk("three_no_commit", bus.commit_valid, 0);
      idle(); wbd(0, 0, 'h11, 0, 0); cyc();
      idle(); cyc(); #1;
      chk("dual_cvalid", bus.commit_valid, 2'b11);
      chk("dual_rd0", bus.commit_rd[4:0], 1);
      chk("dual_rd1", bus.commit_rd[9:5], 2);
      chk("dual_val0", bus.commit_val[31:0], 'h11);
      chk("dual_count", bus.count, 1);
      cyc(); #1;
      chk("single_cvalid", bus.commit_valid, 2'b01);
      chk("single_rd", bus.commit_rd[4:0], 3);
      chk("single_count", bus.count, 0);

      // fill to capacity, overflow issue ignored
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin iss(i, 0, 0, 0, i * 4); cyc(); end
      #1;
      chk("fill_full", bus.full, 1);
      chk("fill_count", bus.count, DEPTH);
      chk("fill_tail", bus.issue_pos, 0);
      iss(30, 0, 0, 1, 'h99); cyc(); #1;
      chk("over_tail", bus.issue_pos, 0);
      chk("over_count", bus.count, DEPTH);
      idle(); wbd(0, 0, 'h55, 0, 0); cyc();
      idle(); #1;
      chk("drain_still_full", bus.full, 1);
      cyc(); #1;
      chk("drain_full", bus.full, 0);
      chk("drain_count", bus.count, DEPTH - 1);

      // mispredicted branch at head blocks slot 1 and flushes
      do_reset();
      iss(0, 2, 0, 0, 'h80); cyc();
      iss(7, 0, 0, 1, 'h84); cyc();
      idle(); wbd(0, 0, 0, 1, 'h100); cyc();
      idle(); cyc(); #1;
      chk("mis_rollback", bus.rollback, 1);
      chk("mis_redirect", bus.redirect_pc, 'h100);
      chk("mis_count", bus.count, 0);
      chk("mis_cvalid", bus.commit_valid, 0);
      chk("mis_br", bus.br_commit, 1);
      chk("mis_bjump", bus.br_jump, 1);
      chk("mis_bpc", bus.br_pc, 'h80);
      iss(5, 0, 0, 1, 'h90); cyc(); #1;
      chk("rb_drop", bus.rollback, 0);
      chk("rb_issue_ignored", bus.count, 0);

      // two stores release on consecutive cycles
      do_reset();
      iss(0, 1, 0, 1, 'h200); cyc();
      iss(0, 1, 0, 1, 'h204); cyc(); #1;
      idle();
      chk("st0_commit", bus.store_commit, 1);
      chk("st0_pos", bus.store_pos, 0);
      cyc(); #1;
      chk("st1_commit", bus.store_commit, 1);
      chk("st1_pos", bus.store_pos, 1);

      // combinational writeback bypass, higher port wins
      do_reset();
      wbd(0, 5, 'hDEAD, 0, 0); bus.rs1_pos = 5; bus.rs2_pos = 6; #1;
      chk("byp_ready", bus.rs1_ready, 1);
      chk("byp_val", bus.rs1_val, 'hDEAD);
      chk("byp_other", bus.rs2_ready, 0);
      wbd(1, 5, 'hBEEF, 0, 0); #1;
      chk("byp_prio", bus.rs1_val, 'hBEEF);

      // asynchronous reset mid-operation
      do_reset();
      for (int i = 0; i < 7; i++) begin iss(i, 0, 0, 0, 0); cyc(); end
      idle(); wbd(0, 2, 'h77, 0, 0); bus.rs1_pos = 2; #1;
      chk("pre_rst_count", bus.count, 7);
      chk("pre_rst_rs1", bus.rs1_ready, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", bus.count, 0);
      chk("arst_tail", bus.issue_pos, 0);
      chk("arst_rs1", bus.rs1_ready, 0);
      chk("arst_rs1_val", bus.rs1_val, 0);
      chk("arst_full", bus.full, 0);

      // randomized traffic against the queue model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rdy = ($urandom_range(0, 9) != 0);
         bus.issue_valid = ($urandom_range(0, 9) < 6);
         bus.issue_rd = 5'($urandom);
         bus.issue_kind = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
         bus.issue_pc = $urandom;
         bus.issue_pred_jump = 1'($urandom);
         bus.issue_ready = ($urandom_range(0, 9) < 4);
         for (int k = 0; k < NUM_WB; k++) begin
            int p;
            if (q.size() > 0 && $urandom_range(0, 3) != 0) p = (mh + $urandom_range(0, q.size() - 1)) % DEPTH;
            else p = $urandom_range(0, DEPTH - 1);
            bus.wb_valid[k] = ($urandom_range(0, 9) < 4);
            bus.wb_pos[k*IDX_W +: IDX_W] = 4'(p);
            bus.wb_val[k*DATA_W +: DATA_W] = $urandom;
            bus.wb_jump[k] = 1'($urandom);
            bus.wb_pc[k*ADDR_W +: ADDR_W] = $urandom;
         end
         bus.rs1_pos = ($urandom_range(0, 2) == 0) ? bus.wb_pos[IDX_W-1:0] : 4'($urandom);
         bus.rs2_pos = 4'($urandom);
         #1;
         compare_model();
         if (rdy) model_step();
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
